dm_tx: RTL and testbench

//  Differential Manchester transmitter: accepts DATA_WIDTH-bit words over a valid/ready

---
 rtl/dm_pkg.sv | 16 +
 rtl/dm_halfbit_cnt.sv | 29 ++
 rtl/dm_tx.sv | 109 ++++++++++
 tb/tb_dm_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared Differential Manchester frame definitions for the tx and rx paths.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA
  } dm_state_t;

  localparam int DM_PREAMBLE_BITS = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_halfbit_cnt.sv
// Loadable half-bit down-counter; tick marks the last cycle of a half-bit.
module dm_halfbit_cnt
  import dm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] div_q,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div_q;
    end else if (en) begin
      cnt <= (cnt == '0) ? div_q : cnt - W'(1);
    end
  end

endmodule

// File: rtl/dm_tx.sv
// Differential Manchester transmitter: preamble of ones, then LSB-first payload.
module dm_tx
  import dm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int PREAMBLE_BITS = DM_PREAMBLE_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNTER_WIDTH-1:0] div,
  input  logic [DATA_WIDTH-1:0]    tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     dm_out,
  output logic                     tx_active,
  output logic                     tx_done
);

  localparam int NMAX =
    (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
  localparam int BW = idx_w(NMAX);

  dm_state_t              state;
  logic [COUNTER_WIDTH-1:0] div_q;
  logic [DATA_WIDTH-1:0]  shift;
  logic [BW-1:0]          bit_idx;
  logic                   half;
  logic                   first;
  logic                   tick;
  logic                   busy;
  logic                   cur_bit;
  logic                   last_bit;

  assign busy    = (state != ST_IDLE);
  assign cur_bit = (state == ST_PRE) | shift[0];
  assign last_bit = (state == ST_PRE)
    ? (bit_idx == BW'(PREAMBLE_BITS - 1))
    : (bit_idx == BW'(DATA_WIDTH - 1));

  dm_halfbit_cnt #(.W(COUNTER_WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (busy && first),
    .en    (busy && !first),
    .div_q (div_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dm_out    <= 1'b0;
      tx_ready  <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      div_q     <= '0;
      shift     <= '0;
      bit_idx   <= '0;
      half      <= 1'b0;
      first     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            state     <= ST_PRE;
            tx_ready  <= 1'b0;
            tx_active <= 1'b1;
            shift     <= tx_data;
            div_q     <= div;
            bit_idx   <= '0;
            half      <= 1'b0;
            first     <= 1'b1;
          end
        end
        ST_PRE, ST_DATA: begin
          if (first) begin
            first  <= 1'b0;
            dm_out <= ~dm_out;
          end else if (tick) begin
            half <= ~half;
            if (!half) begin
              if (cur_bit) dm_out <= ~dm_out;
            end else if (last_bit) begin
              // last data bit closes the frame without a start toggle
              if (state == ST_PRE) begin
                state   <= ST_DATA;
                bit_idx <= '0;
                dm_out  <= ~dm_out;
              end else begin
                state     <= ST_IDLE;
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              dm_out  <= ~dm_out;
              if (state == ST_DATA) shift <= shift >> 1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_tx.sv
// Bench for dm_tx: schedule-based line model plus frame decoding of dm_out.
module tb_dm_tx;

  localparam int PB = 4;
  localparam int DW = 8;
  localparam int NB = PB + DW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] div = 16'd3;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        dm_out;
  logic        tx_active;
  logic        tx_done;

  int vecs = 0;
  int fails = 0;
  bit chk_en = 0;

  dm_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div       (div),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .dm_out    (dm_out),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: on accept, the whole frame is a list of toggle times.
  int cyc = 0;
  bit m_busy = 0, m_ready = 0, m_out = 0, m_active = 0, m_done = 0;
  int m_done_t = 0;
  int tq[$];
  int mh, ms;
  bit mv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ready = 0; m_out = 0; m_active = 0; m_done = 0;
      tq.delete();
    end else begin
      cyc++;
      m_done = 0;
      if (m_busy) begin
        if (tq.size() > 0 && tq[0] == cyc) begin
          m_out = !m_out;
          void'(tq.pop_front());
        end
        if (cyc == m_done_t) begin
          m_busy = 0; m_active = 0; m_done = 1;
        end
      end else if (m_ready && tx_valid) begin
        mh = int'(div) + 1;
        ms = cyc + 1;
        for (int b = 0; b < NB; b++) begin
          mv = (b < PB) ? 1'b1 : tx_data[b-PB];
          tq.push_back(ms + 2*b*mh);
          if (mv) tq.push_back(ms + (2*b+1)*mh);
        end
        m_done_t = ms + 2*NB*mh;
        m_busy = 1; m_ready = 0; m_active = 1;
      end else begin
        m_ready = 1;
      end
    end
  end

  // Per-cycle compare plus capture of observed line edges.
  int dut_tog[$];
  int done_cyc = 0;
  logic prev_out = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dm_out", dm_out, m_out);
      chk("tx_ready", tx_ready, m_ready);
      chk("tx_active", tx_active, m_active);
      chk("tx_done", tx_done, m_done);
    end
    if (dm_out !== prev_out) dut_tog.push_back(cyc);
    prev_out = dm_out;
    if (tx_done) done_cyc = cyc;
  end

  function automatic bit has(input int t);
    foreach (dut_tog[i]) if (dut_tog[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_active(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (tx_active) ok = 1;
    end
    chk("active_seen", ok, 1);
  endtask

  task automatic wait_done(input int maxc, input bit jitter, input bit hold);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (tx_done) ok = 1;
      else if (jitter) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
        div      = 16'($urandom);
      end
    end
    if (!hold) tx_valid = 1'b0;
    chk("done_seen", ok, 1);
  endtask

  task automatic send(input logic [7:0] d, input int dv, input bit hold);
    @(negedge clk);
    tx_data  = d;
    div      = 16'(dv);
    tx_valid = 1'b1;
    dut_tog.delete();
    wait_active(20);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [7:0] w,
                             input int h, input int len, input int ntog);
    logic [7:0] got;
    int pre, t0;
    #1;
    if (dut_tog.size() == 0) begin
      chk({nm, "_toggles"}, 0, ntog);
      return;
    end
    t0 = dut_tog[0];
    chk({nm, "_len"}, done_cyc - t0, len);
    chk({nm, "_toggles"}, dut_tog.size(), ntog);
    pre = 0;
    for (int b = 0; b < PB; b++) if (has(t0 + (2*b+1)*h)) pre++;
    chk({nm, "_preamble"}, pre, PB);
    for (int i = 0; i < DW; i++) got[i] = has(t0 + (2*(PB+i)+1)*h);
    chk({nm, "_word"}, got, w);
  endtask

  initial begin
    int d1, dv;
    logic [7:0] rd;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_dm_out", dm_out, 0);
    chk("rst_tx_ready", tx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", tx_ready, 1);
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);

    send(8'hA5, 3, 0);
    wait_done(150, 0, 0);
    check_frame("a5", 8'hA5, 4, 96, 20);

    send(8'h00, 0, 0);
    wait_done(60, 0, 0);
    check_frame("zero", 8'h00, 1, 24, 16);

    send(8'h5A, 3, 1);
    repeat (5) @(negedge clk);
    tx_data = 8'hC3;
    div     = 16'd7;
    wait_done(150, 0, 1);
    check_frame("hold1", 8'h5A, 4, 96, 20);
    d1 = done_cyc;
    dut_tog.delete();
    wait_active(20);
    tx_valid = 1'b0;
    wait_done(300, 0, 0);
    check_frame("next", 8'hC3, 8, 192, 20);
    if (dut_tog.size() > 0) chk("gap", (dut_tog[0] - d1) >= 3, 1);

    send(8'h3C, 2, 0);
    repeat (2*(PB+3)*3 + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_dm_out", dm_out, 0);
    chk("abort_active", tx_active, 0);
    chk("abort_ready", tx_ready, 0);
    chk("abort_done", tx_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C, 2, 0);
    wait_done(120, 0, 0);
    check_frame("after_rst", 8'h3C, 3, 72, 20);

    send(8'hFF, 1, 0);
    wait_done(80, 0, 0);
    check_frame("ff", 8'hFF, 2, 48, 24);

    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom);
      dv = $urandom_range(0, 3);
      send(rd, dv, 0);
      wait_done(24*(dv+1) + 10, 1, 0);
      check_frame("rand", rd, dv+1, 24*(dv+1), 16 + $countones(rd));
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
